// File: rtl/psum_pkg.sv
// Shared types and constants for the partial-sum datapath: widths, output FIFO entry,
// pool FSM states and the ReLU/shift/saturate quantizer.
package psum_pkg;

   localparam int unsigned PSUM_W  = 16;
   localparam int unsigned ACT_W   = 8;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned BYTES_W = 3;

   typedef struct packed {
      logic               last;
      logic [BYTES_W-1:0] bytes;
      logic [WORD_W-1:0]  data;
   } fifo_entry_t;

   localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

   typedef enum logic {PoolEmpty, PoolHold} pool_state_e;

   // Negative sums clamp to zero; non-negative sums are shifted then clipped to one byte.
   function automatic logic [ACT_W-1:0] quantize(input logic [PSUM_W-1:0] x,
                                                 input int unsigned       sh);
      logic [PSUM_W-1:0] s;
      s = x >> sh;
      if (x[PSUM_W-1]) return '0;
      if (s > PSUM_W'(255)) return '1;
      return s[ACT_W-1:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a read and a write in the same cycle are
// both honoured even when full. Read data is zero while empty.
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4,
   localparam int unsigned CntW = $clog2(Depth + 1),
   localparam int unsigned PtrW = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [Width-1:0] wr_data,
   input  logic             rd_en,
   output logic [Width-1:0] rd_data,
   output logic [CntW-1:0]  count,
   output logic             empty
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             full, wr_fire, rd_fire;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(Depth));
   assign count   = count_q;
   assign rd_fire = rd_en && !empty;
   assign wr_fire = wr_en && (!full || rd_fire);
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_fire) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(wr_fire) - CntW'(rd_fire);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
   end

   // Upstream throttling must make a write into a full, non-draining FIFO impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) wr_en |-> (!full || rd_en));

endmodule

// File: rtl/psum_postproc.sv
// Accumulator post-processing: ReLU/shift/saturate, optional max-pool of pairs, byte packing
// four per word, and an output FIFO with valid/ready handshake.
module psum_postproc
   import psum_pkg::*;
#(
   parameter int unsigned SHIFT      = 4,
   parameter int unsigned POOL       = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                acc_valid,
   output logic                acc_ready,
   input  logic [PSUM_W-1:0]   acc_data,
   input  logic                acc_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORD_W-1:0]   out_data,
   output logic [BYTES_W-1:0]  out_bytes,
   output logic                out_last
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic [ACT_W-1:0]  s1_data_q, s1_data_d;
   pool_state_e       state_q, state_d;
   logic [ACT_W-1:0]  held_q, held_d;
   logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
   logic [ACT_W-1:0]  s2_data_q, s2_data_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [WORD_W-1:0] pack_q, pack_d, lane_word;
   logic              fifo_wr, fifo_empty;
   logic [CntW-1:0]   fifo_count;
   fifo_entry_t       wr_entry, rd_entry;
   logic [ENTRY_W-1:0] rd_bits;

   // Three words can be in flight behind a ready decision, hence the DEPTH-3 threshold.
   assign acc_ready = (fifo_count <= CntW'(FIFO_DEPTH - 3));

   always_comb begin
      s1_valid_d = acc_valid && acc_ready;
      s1_last_d  = acc_last && s1_valid_d;
      s1_data_d  = quantize(acc_data, SHIFT);
   end

   always_comb begin
      state_d    = state_q;
      held_d     = held_q;
      s2_valid_d = 1'b0;
      s2_last_d  = 1'b0;
      s2_data_d  = s2_data_q;
      if (s1_valid_q) begin
         if (POOL == 1) begin
            s2_valid_d = 1'b1;
            s2_last_d  = s1_last_q;
            s2_data_d  = s1_data_q;
         end else begin
            unique case (state_q)
               PoolEmpty: begin
                  if (s1_last_q) begin
                     s2_valid_d = 1'b1;
                     s2_last_d  = 1'b1;
                     s2_data_d  = s1_data_q;
                  end else begin
                     held_d  = s1_data_q;
                     state_d = PoolHold;
                  end
               end
               PoolHold: begin
                  s2_valid_d = 1'b1;
                  s2_last_d  = s1_last_q;
                  s2_data_d  = (s1_data_q > held_q) ? s1_data_q : held_q;
                  state_d    = PoolEmpty;
               end
               default: state_d = PoolEmpty;
            endcase
         end
      end
   end

   always_comb begin
      lane_word      = pack_q | (WORD_W'(s2_data_q) << {cnt_q, 3'b000});
      fifo_wr        = s2_valid_q && ((cnt_q == 2'd3) || s2_last_q);
      wr_entry.last  = s2_last_q;
      wr_entry.bytes = {1'b0, cnt_q} + 3'd1;
      wr_entry.data  = lane_word;
      cnt_d          = cnt_q;
      pack_d         = pack_q;
      if (s2_valid_q) begin
         cnt_d  = fifo_wr ? 2'd0 : cnt_q + 2'd1;
         pack_d = fifo_wr ? '0 : lane_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_data_q  <= '0;
         state_q    <= PoolEmpty;
         held_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_data_q  <= '0;
         cnt_q      <= '0;
         pack_q     <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_last_q  <= s1_last_d;
         s1_data_q  <= s1_data_d;
         state_q    <= state_d;
         held_q     <= held_d;
         s2_valid_q <= s2_valid_d;
         s2_last_q  <= s2_last_d;
         s2_data_q  <= s2_data_d;
         cnt_q      <= cnt_d;
         pack_q     <= pack_d;
      end
   end

   sync_fifo #(
      .Width (ENTRY_W),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (fifo_wr),
      .wr_data (wr_entry),
      .rd_en   (out_ready),
      .rd_data (rd_bits),
      .count   (fifo_count),
      .empty   (fifo_empty)
   );

   assign rd_entry  = rd_bits;
   assign out_valid = !fifo_empty;
   assign out_data  = rd_entry.data;
   assign out_bytes = rd_entry.bytes;
   assign out_last  = rd_entry.last;

endmodule

// File: tb/tb_psum_postproc.sv
// Directed bench for psum_postproc: a bypass-pool and a pair-pool instance share one
// stimulus bus; per-instance scoreboards hold the expected words.
module tb_psum_postproc;
   import psum_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        acc_valid, acc_last, sel2, out_ready;
   logic [15:0] acc_data;
   logic        v1, v2, rdy1, rdy2, acc_ready_m;
   logic        ov1, ov2, ol1, ol2;
   logic [31:0] od1, od2;
   logic [2:0]  ob1, ob2;

   int n_vec = 0;
   int n_err = 0;
   logic [35:0] q1[$];
   logic [35:0] q2[$];
   int          cnt_snap;

   always #5 clk = ~clk;

   assign v1          = acc_valid && !sel2;
   assign v2          = acc_valid && sel2;
   assign acc_ready_m = sel2 ? rdy2 : rdy1;

   psum_postproc #(.SHIFT(4), .POOL(1), .FIFO_DEPTH(4)) dut1 (
      .clk(clk), .rst(rst), .acc_valid(v1), .acc_ready(rdy1), .acc_data(acc_data),
      .acc_last(acc_last), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
      .out_bytes(ob1), .out_last(ol1)
   );

   psum_postproc #(.SHIFT(4), .POOL(2), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .rst(rst), .acc_valid(v2), .acc_ready(rdy2), .acc_data(acc_data),
      .acc_last(acc_last), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
      .out_bytes(ob2), .out_last(ol2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitors: pop the scoreboard on each handshake, check stability under stall.
   logic        stall1 = 1'b0, stall2 = 1'b0;
   logic [35:0] hold1, hold2;

   always @(negedge clk) begin
      logic [35:0] e;
      if (rst) begin
         stall1 = 1'b0;
      end else begin
         if (stall1) check("stable1", {ol1, ob1, od1}, hold1);
         if (ov1 && out_ready) begin
            if (q1.size() == 0) check("spurious1", ov1, 1'b0);
            else begin
               e = q1.pop_front();
               check("word1", {ol1, ob1, od1}, e);
            end
         end
         stall1 = ov1 && !out_ready;
         hold1  = {ol1, ob1, od1};
      end
   end

   always @(negedge clk) begin
      logic [35:0] e;
      if (rst) begin
         stall2 = 1'b0;
      end else begin
         if (stall2) check("stable2", {ol2, ob2, od2}, hold2);
         if (ov2 && out_ready) begin
            if (q2.size() == 0) check("spurious2", ov2, 1'b0);
            else begin
               e = q2.pop_front();
               check("word2", {ol2, ob2, od2}, e);
            end
         end
         stall2 = ov2 && !out_ready;
         hold2  = {ol2, ob2, od2};
      end
   end

   task automatic step(input logic v, input logic [15:0] d, input logic l, output logic acc);
      acc_valid = v;
      acc_data  = d;
      acc_last  = l;
      @(negedge clk);
      acc      = v && acc_ready_m;
      cnt_snap = int'(dut1.fifo_count);
      @(posedge clk);
      #1;
      acc_valid = 1'b0;
      acc_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      logic a;
      repeat (n) step(1'b0, 16'h0, 1'b0, a);
   endtask

   task automatic send(input logic [15:0] d, input logic l);
      logic a;
      a = 1'b0;
      for (int n = 0; n < 50 && !a; n++) step(1'b1, d, l, a);
      check("accept", a, 1'b1);
   endtask

   // One last-flagged sample whose quantized byte is b; expectation queued on acceptance.
   task automatic feed(input logic [7:0] b, output logic a);
      step(1'b1, {4'h0, b, 4'h0}, 1'b1, a);
      if (a) q1.push_back({1'b1, 3'd1, 24'd0, b});
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && (q1.size() != 0 || q2.size() != 0); n++) idle(1);
      check("drain", 64'(q1.size() + q2.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ov1"}, ov1, 1'b0);
      check({tag, "_od1"}, od1, 32'h0);
      check({tag, "_ob1"}, ob1, 3'd0);
      check({tag, "_ol1"}, ol1, 1'b0);
      check({tag, "_rdy1"}, rdy1, 1'b1);
      check({tag, "_ov2"}, ov2, 1'b0);
      check({tag, "_rdy2"}, rdy2, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic a;
      int   acc_cnt, maxc, nb;
      rst       = 1'b1;
      acc_valid = 1'b0;
      acc_last  = 1'b0;
      acc_data  = 16'h0;
      sel2      = 1'b0;
      out_ready = 1'b1;
      #1;
      check_reset_outputs("rst");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // Quantize and pack, bypass pool.
      q1.push_back({1'b1, 3'd4, 32'hFF00FF10});
      send(16'h0100, 1'b0);
      send(16'h0FF0, 1'b0);
      send(16'hFFF0, 1'b0);
      send(16'h7FFF, 1'b1);
      drain();

      // Pair pooling with an odd tail.
      sel2 = 1'b1;
      q2.push_back({1'b1, 3'd3, 32'h00A00530});
      send(16'h0200, 1'b0);
      send(16'h0300, 1'b0);
      send(16'h0050, 1'b0);
      send(16'h0010, 1'b0);
      send(16'h0A00, 1'b1);
      drain();
      sel2 = 1'b0;

      // Latency: accept in cycle t, out_valid first seen in t+3.
      idle(3);
      q1.push_back({1'b1, 3'd1, 32'h00000012});
      step(1'b1, 16'h0123, 1'b1, a);
      check("lat_accept", a, 1'b1);
      @(negedge clk) check("lat_t1", ov1, 1'b0);
      @(negedge clk) check("lat_t2", ov1, 1'b0);
      @(negedge clk) check("lat_t3", ov1, 1'b1);
      @(posedge clk);
      #1;
      drain();

      // Backpressure: 20 single-byte rows with the consumer stalled at first.
      out_ready = 1'b0;
      acc_cnt   = 0;
      maxc      = 0;
      for (int i = 0; i < 12; i++) begin
         feed(8'(acc_cnt + 1), a);
         check("bp_ready", a, 1'(cnt_snap < 2));
         if (a) acc_cnt++;
         if (cnt_snap > maxc) maxc = cnt_snap;
      end
      check("bp_accepted", 64'(acc_cnt), 64'd4);
      check("bp_max", 64'(maxc), 64'd4);
      out_ready = 1'b1;
      for (int i = acc_cnt; i < 20; i++) begin
         q1.push_back({1'b1, 3'd1, 24'd0, 8'(i + 1)});
         send({4'h0, 8'(i + 1), 4'h0}, 1'b1);
      end
      drain();

      // Simultaneous read/write: fill, then stream with the consumer always ready.
      out_ready = 1'b0;
      nb        = 100;
      for (int i = 0; i < 12; i++) begin
         feed(8'(nb), a);
         if (a) nb++;
      end
      check("rw_full", 64'(dut1.fifo_count), 64'd4);
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         feed(8'(nb), a);
         if (a) nb++;
         if (i >= 10) check("rw_count", 64'(cnt_snap), 64'd1);
      end
      drain();

      // Reset mid-word discards the partial word.
      send(16'h0550, 1'b0);
      send(16'h0660, 1'b0);
      idle(3);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid");
      @(posedge clk);
      #1 rst = 1'b0;
      idle(5);
      check("mid_no_out", ov1, 1'b0);
      q1.push_back({1'b1, 3'd4, 32'h04030201});
      send(16'h0010, 1'b0);
      send(16'h0020, 1'b0);
      send(16'h0030, 1'b0);
      send(16'h0040, 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
